// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: run sequencer driving PE_Array_Busy/Inst_Addr for the PE array; Run_Cycles counter built only with PE_ARRAY_CTRL_PERF_CNT_EN
module pe_array_ctrl #(
  parameter int IM_AWIDTH = 8,
  parameter int ITER_WIDTH = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Abort,
  input  logic                  Pause,
  input  logic [IM_AWIDTH-1:0]  Inst_Num,
  input  logic [ITER_WIDTH-1:0] Iter_Num,
  output logic                  PE_Array_Busy,
  output logic [IM_AWIDTH-1:0]  Inst_Addr,
  output logic [ITER_WIDTH-1:0] Iter_Cnt,
  output logic                  Idle,
  output logic                  Done,
  output logic [31:0]           Run_Cycles
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  state_t state, state_nxt;
  logic [IM_AWIDTH-1:0] inst_num_q, addr_nxt;
  logic [ITER_WIDTH-1:0] iter_num_q, iter_nxt;
  logic [7:0] drain_cnt, drain_nxt;
  logic busy_nxt, start_ok, issue, last_inst, last_iter, run_end, drain_end;
  assign start_ok = state == IDLE && Start && !Abort;
  assign issue = state == RUN && PE_Array_Busy;
  assign last_inst = Inst_Addr == inst_num_q - IM_AWIDTH'(1);
  assign last_iter = Iter_Cnt == iter_num_q - ITER_WIDTH'(1);
  assign run_end = issue && last_inst && last_iter;
  assign drain_end = state == DRAIN && PE_Array_Busy && drain_cnt == DRAIN_LAST;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      PE_Array_Busy <= 1'b0;
      Inst_Addr <= '0;
      Iter_Cnt <= '0;
      Idle <= 1'b1;
      Done <= 1'b0;
      drain_cnt <= '0;
      inst_num_q <= '0;
      iter_num_q <= '0;
    end else begin
      state <= state_nxt;
      PE_Array_Busy <= busy_nxt;
      Inst_Addr <= addr_nxt;
      Iter_Cnt <= iter_nxt;
      Idle <= state_nxt == IDLE;
      Done <= state_nxt == DONE;
      drain_cnt <= drain_nxt;
      if (start_ok) begin
        inst_num_q <= Inst_Num;
        iter_num_q <= Iter_Num;
      end
    end
  end
  always_comb begin
    state_nxt = Abort ? IDLE
      : state == IDLE ? (Start ? ((Inst_Num == '0 || Iter_Num == '0) ? DONE : RUN) : IDLE)
      : state == RUN ? (run_end ? (DRAIN_CYCLES > 0 ? DRAIN : DONE) : RUN)
      : state == DRAIN ? (drain_end ? DONE : DRAIN)
      : IDLE;
  end
  always_comb begin
    busy_nxt = (state_nxt == RUN || state_nxt == DRAIN) && (state == IDLE || !Pause);
    addr_nxt = (state != RUN || Abort || (issue && last_inst)) ? '0 : issue ? Inst_Addr + IM_AWIDTH'(1) : Inst_Addr;
    iter_nxt = (Abort || start_ok) ? '0 : (issue && last_inst && !last_iter) ? Iter_Cnt + ITER_WIDTH'(1) : Iter_Cnt;
    drain_nxt = state == DRAIN ? drain_cnt + {7'd0, PE_Array_Busy} : '0;
  end
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Reset || start_ok) Run_Cycles <= '0;
    else if ((state == RUN || state == DRAIN) && Run_Cycles != '1) Run_Cycles <= Run_Cycles + 32'd1;
  end
`else
  assign Run_Cycles = '0;
`endif
endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: randomized and directed checks of pe_array_ctrl against an instruction-count model
module tb_pe_array_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1, Start = 1'b0, Abort = 1'b0, Pause = 1'b0;
  logic [7:0] Inst_Num = '0;
  logic [15:0] Iter_Num = '0;
  logic [1:0] o_busy, o_idle, o_done;
  logic [1:0][7:0] o_addr;
  logic [1:0][15:0] o_iter;
  logic [1:0][31:0] o_rc;
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int DR[2] = '{4, 0};
  int checks = 0, failures = 0;
  int m_phase[2], m_k[2], m_n[2], m_m[2], m_dr[2], m_iter[2];
  bit m_busy[2];
  longint m_rc[2];
  int pin_on = 0, pin_inst = 0, pin_busy = 0, pin_lat = 0, pin_rc = 0, pin_paddr = -1;
  int chk_req = 0, tmo = 0, lat = 1, bcnt = 0, dones = 0;
  bit ab_q = 1'b0, rst_q = 1'b1;

  pe_array_ctrl #(.DRAIN_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Pause(Pause),
    .Inst_Num(Inst_Num), .Iter_Num(Iter_Num), .PE_Array_Busy(o_busy[0]),
    .Inst_Addr(o_addr[0]), .Iter_Cnt(o_iter[0]), .Idle(o_idle[0]), .Done(o_done[0]),
    .Run_Cycles(o_rc[0])
  );
  pe_array_ctrl #(.DRAIN_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Pause(Pause),
    .Inst_Num(Inst_Num), .Iter_Num(Iter_Num), .PE_Array_Busy(o_busy[1]),
    .Inst_Addr(o_addr[1]), .Iter_Cnt(o_iter[1]), .Idle(o_idle[1]), .Done(o_done[1]),
    .Run_Cycles(o_rc[1])
  );

  always #5 Clk = ~Clk;

  // Model: a run is n*m issues; address/iteration follow from the issue count k.
  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_phase[i] = 0; m_busy[i] = 0; m_k[i] = 0; m_n[i] = 0; m_m[i] = 0;
        m_dr[i] = 0; m_iter[i] = 0; m_rc[i] = 0;
      end else begin
        if ((m_phase[i] == 1 || m_phase[i] == 2) && m_rc[i] < 64'hFFFF_FFFF) m_rc[i]++;
        if (Abort) begin
          m_phase[i] = 0; m_busy[i] = 0; m_k[i] = 0; m_iter[i] = 0;
        end else if (m_phase[i] == 0) begin
          if (Start) begin
            m_n[i] = int'(Inst_Num); m_m[i] = int'(Iter_Num);
            m_k[i] = 0; m_iter[i] = 0; m_rc[i] = 0;
            m_phase[i] = (m_n[i] == 0 || m_m[i] == 0) ? 3 : 1;
            m_busy[i] = m_phase[i] == 1;
          end
        end else if (m_phase[i] == 1) begin
          if (m_busy[i]) begin
            m_k[i]++;
            if (m_k[i] == m_n[i] * m_m[i]) begin
              m_phase[i] = DR[i] > 0 ? 2 : 3; m_dr[i] = 0; m_iter[i] = m_m[i] - 1;
            end else m_iter[i] = m_k[i] / m_n[i];
          end
          m_busy[i] = m_phase[i] != 3 && !Pause;
        end else if (m_phase[i] == 2) begin
          if (m_busy[i]) begin
            m_dr[i]++;
            if (m_dr[i] == DR[i]) m_phase[i] = 3;
          end
          m_busy[i] = m_phase[i] != 3 && !Pause;
        end else m_phase[i] = 0;
      end
    end
  end

  task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d got=%0d want=%0d t=%0t", nm, i, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("busy", i, 64'(o_busy[i]), 64'(m_busy[i]));
      chk("addr", i, 64'(o_addr[i]), m_phase[i] == 1 ? 64'(m_k[i] % m_n[i]) : 64'd0);
      chk("iter", i, 64'(o_iter[i]), 64'(m_iter[i]));
      chk("idle", i, 64'(o_idle[i]), 64'(m_phase[i] == 0));
      chk("done", i, 64'(o_done[i]), 64'(m_phase[i] == 3));
      chk("run_cycles", i, 64'(o_rc[i]), PERF ? 64'(m_rc[i]) : 64'd0);
    end
    if (rst_q || ab_q) begin
      chk("clr_idle", 0, 64'(o_idle[0]), 64'd1);
      chk("clr_busy", 0, 64'(o_busy[0]), 64'd0);
      chk("clr_addr", 0, 64'(o_addr[0]), 64'd0);
      chk("clr_iter", 0, 64'(o_iter[0]), 64'd0);
      chk("clr_done", 0, 64'(o_done[0]), 64'd0);
    end
    if (rst_q) chk("clr_rc", 0, 64'(o_rc[0]), 64'd0);
    if (pin_on != 0) begin
      if (o_idle[pin_inst]) begin
        lat = 1; bcnt = 0;
      end else begin
        lat++; bcnt += int'(o_busy[pin_inst]);
      end
      if (o_done[pin_inst]) begin
        chk("pin_busy_cycles", pin_inst, 64'(bcnt), 64'(pin_busy));
        chk("pin_done_latency", pin_inst, 64'(lat), 64'(pin_lat));
        chk("pin_run_cycles", pin_inst, 64'(o_rc[pin_inst]), 64'(pin_rc));
      end
      if (pin_paddr >= 0 && !o_idle[pin_inst] && !o_busy[pin_inst] && !o_done[pin_inst])
        chk("pin_pause_addr", pin_inst, 64'(o_addr[pin_inst]), 64'(pin_paddr));
    end
    dones += int'(o_done[0]);
    if (chk_req == 1) chk("done_count", 0, 64'(dones), 64'd6);
    if (chk_req == 2) chk("timeout", 0, 64'(tmo), 64'd0);
    ab_q = Abort;
    rst_q = Reset;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic run(input int n, input int m);
    Inst_Num = 8'(n); Iter_Num = 16'(m); Start = 1'b1;
    cyc(1);
    Start = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int c;
    for (c = 0; c < 300; c++) begin
      if (o_idle[i]) break;
      cyc(1);
    end
    if (c == 300) tmo = 1;
    cyc(2);
  endtask

  task automatic pins(input int inst, input int b, input int l, input int rc, input int pa);
    pin_inst = inst; pin_busy = b; pin_lat = l; pin_rc = PERF ? rc : 0; pin_paddr = pa; pin_on = 1;
  endtask

  initial begin
    cyc(3);
    Reset = 1'b0;
    cyc(2);
    pins(0, 10, 12, 10, -1);
    run(3, 2);
    wait_idle(0);
    pins(0, 10, 15, 13, 1);
    run(3, 2);
    Pause = 1'b1;
    cyc(3);
    Pause = 1'b0;
    wait_idle(0);
    pins(0, 0, 2, 0, -1);
    run(0, 5);
    wait_idle(0);
    run(4, 0);
    wait_idle(0);
    pin_on = 0;
    run(4, 3);
    cyc(4);
    Abort = 1'b1;
    cyc(1);
    Abort = 1'b0;
    wait_idle(0);
    Abort = 1'b1; Start = 1'b1; Inst_Num = 8'd2; Iter_Num = 16'd2;
    cyc(1);
    Abort = 1'b0; Start = 1'b0;
    cyc(3);
    pins(0, 10, 12, 10, -1);
    run(3, 2);
    cyc(1);
    Start = 1'b1; Inst_Num = 8'd7; Iter_Num = 16'd9;
    cyc(3);
    Start = 1'b0;
    wait_idle(0);
    pin_on = 0;
    run(3, 2);
    cyc(7);
    Reset = 1'b1;
    cyc(1);
    Reset = 1'b0;
    cyc(1);
    pins(1, 5, 7, 5, -1);
    run(1, 5);
    wait_idle(1);
    wait_idle(0);
    pin_on = 0;
    chk_req = 1;
    cyc(1);
    chk_req = 0;
    for (int n = 0; n < 2500; n++) begin
      Reset = $urandom_range(0, 199) == 0;
      Abort = $urandom_range(0, 39) == 0;
      Pause = $urandom_range(0, 3) == 0;
      Start = $urandom_range(0, 2) == 0;
      Inst_Num = 8'($urandom_range(0, 4));
      Iter_Num = 16'($urandom_range(0, 3));
      cyc(1);
    end
    Reset = 1'b0; Abort = 1'b0; Pause = 1'b0; Start = 1'b0;
    cyc(30);
    chk_req = 2;
    cyc(1);
    chk_req = 0;
    cyc(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
